// File: rtl/nclic_pkg.sv
// Shared NCLIC widths and types used by the tree, the pending bank and the dispatcher.
package nclic_pkg;

  localparam int unsigned Priorities = 4;
  localparam int unsigned IntAmount  = 8;
  localparam int unsigned NestDepth  = Priorities;
  localparam int unsigned PrioWidth  = $clog2(Priorities);
  localparam int unsigned IntIdWidth = $clog2(IntAmount);
  localparam int unsigned DepthWidth = $clog2(NestDepth + 1);

  typedef logic [PrioWidth-1:0]  IntPrio;
  typedef logic [IntIdWidth-1:0] IntId;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } disp_state_e;

  // Request payload latched when an interrupt wins preemption.
  typedef struct packed {
    IntId   id;
    IntPrio prio;
  } irq_req_t;

endpackage

// File: rtl/prio_stack.sv
// Nesting stack of handler priorities; top, depth, empty and full are all registered.
module prio_stack #(
  parameter int unsigned Depth      = 4,
  parameter int unsigned Width      = 2,
  parameter int unsigned DepthWidth = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [Width-1:0]      din,
  output logic [Width-1:0]      top,
  output logic [DepthWidth-1:0] depth,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]      mem [Depth];
  logic                  do_pop;
  logic                  do_push;
  logic [DepthWidth-1:0] base;
  logic [DepthWidth-1:0] depth_n;
  logic [Width-1:0]      top_n;

  // A pop is applied before a push, so push+pop overwrites the current top slot.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    base    = do_pop ? depth - DepthWidth'(1) : depth;
    depth_n = base + DepthWidth'(do_push);
    top_n   = top;
    if (do_push) begin
      top_n = din;
    end else if (do_pop) begin
      top_n = (depth >= DepthWidth'(2)) ? mem[AddrWidth'(depth - DepthWidth'(2))] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[AddrWidth'(base)] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top   <= '0;
      depth <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      top   <= top_n;
      depth <= depth_n;
      empty <= (depth_n == '0);
      full  <= (depth_n == DepthWidth'(Depth));
    end
  end

endmodule

// File: rtl/nclic_dispatch.sv
// Takes the tree winner, requests the core when it preempts, and tracks nesting on ack/return.
module nclic_dispatch
  import nclic_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   tree_valid,
  input  IntId   tree_id,
  input  IntPrio tree_prio,
  output logic   irq_req,
  output IntId   irq_id,
  input  logic   irq_ack,
  input  logic   irq_ret,
  output logic   clr_pending,
  output IntId   clr_id,
  output IntPrio cur_prio,
  output logic   active,
  output logic   ret_err
);

  disp_state_e           state, state_n;
  irq_req_t              req_q, req_n;
  logic                  irq_req_n;
  logic                  clr_n;
  IntId                  clr_id_n;
  logic                  err_n;
  logic                  preempt;
  logic                  take;
  logic                  push;
  IntPrio                stk_top;
  logic [DepthWidth-1:0] stk_depth;
  logic                  stk_empty;
  logic                  stk_full;

  assign cur_prio = stk_top;
  assign active   = !stk_empty;
  assign irq_id   = req_q.id;

  assign preempt = tree_valid && (stk_empty || (tree_prio > stk_top));
  assign take    = (state == REQ) && irq_ack;
  assign push    = take && (!stk_full || irq_ret);

  prio_stack #(
    .Depth     (NestDepth),
    .Width     (PrioWidth),
    .DepthWidth(DepthWidth)
  ) u_stack (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (irq_ret),
    .din  (req_q.prio),
    .top  (stk_top),
    .depth(stk_depth),
    .empty(stk_empty),
    .full (stk_full)
  );

  // Next state and next registered outputs; the request is frozen while in REQ.
  always_comb begin
    state_n   = state;
    req_n     = req_q;
    irq_req_n = irq_req;
    clr_n     = 1'b0;
    clr_id_n  = clr_id;
    err_n     = irq_ret && (stk_depth == '0);
    case (state)
      IDLE: begin
        if (preempt) begin
          state_n   = REQ;
          irq_req_n = 1'b1;
          req_n.id   = tree_id;
          req_n.prio = tree_prio;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_n   = IDLE;
          irq_req_n = 1'b0;
          clr_n     = 1'b1;
          clr_id_n  = req_q.id;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_q       <= '0;
      irq_req     <= 1'b0;
      clr_pending <= 1'b0;
      clr_id      <= '0;
      ret_err     <= 1'b0;
    end else begin
      state       <= state_n;
      req_q       <= req_n;
      irq_req     <= irq_req_n;
      clr_pending <= clr_n;
      clr_id      <= clr_id_n;
      ret_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_nclic_dispatch.sv
// Directed vector table plus randomized run against a queue-based model of the dispatcher.
module tb_nclic_dispatch;
  import nclic_pkg::*;

  localparam int unsigned OutW = 2 * IntIdWidth + PrioWidth + 4;

  logic   clk;
  logic   reset;
  logic   tree_valid;
  IntId   tree_id;
  IntPrio tree_prio;
  logic   irq_req;
  IntId   irq_id;
  logic   irq_ack;
  logic   irq_ret;
  logic   clr_pending;
  IntId   clr_id;
  IntPrio cur_prio;
  logic   active;
  logic   ret_err;

  nclic_dispatch dut (
    .clk        (clk),
    .reset      (reset),
    .tree_valid (tree_valid),
    .tree_id    (tree_id),
    .tree_prio  (tree_prio),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .irq_ret    (irq_ret),
    .clr_pending(clr_pending),
    .clr_id     (clr_id),
    .cur_prio   (cur_prio),
    .active     (active),
    .ret_err    (ret_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        tv;
    int unsigned id;
    int unsigned pr;
    logic        ack;
    logic        ret;
    logic        e_req;
    int unsigned e_id;
    logic        e_clr;
    int unsigned e_cid;
    int unsigned e_cur;
    logic        e_act;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a stack of running priorities plus one pending request.
  int   q[$];
  bit   pend;
  int   rid, rprio;
  int   m_id, m_cid;
  bit   m_clr, m_err;

  function automatic vec_t mk(logic rst, logic tv, int unsigned id, int unsigned pr,
                              logic ack, logic ret, logic req, int unsigned rq_id,
                              logic clr, int unsigned cid, int unsigned cur,
                              logic act, logic err);
    vec_t v;
    v.rst = rst; v.tv = tv; v.id = id; v.pr = pr; v.ack = ack; v.ret = ret;
    v.e_req = req; v.e_id = rq_id; v.e_clr = clr; v.e_cid = cid;
    v.e_cur = cur; v.e_act = act; v.e_err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [OutW-1:0] got,
                       input logic [OutW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {req,id,clr,cid,cur,act,err}=%b expected %b", name, got, exp);
    end
  endtask

  function automatic logic [OutW-1:0] dut_out();
    return {irq_req, irq_id, clr_pending, clr_id, cur_prio, active, ret_err};
  endfunction

  function automatic logic [OutW-1:0] model_out();
    int top;
    top = (q.size() > 0) ? q[q.size()-1] : 0;
    return {pend, IntIdWidth'(m_id), m_clr, IntIdWidth'(m_cid), PrioWidth'(top),
            (q.size() > 0), m_err};
  endfunction

  task automatic model_step();
    int  sz, top;
    bit  pre;
    if (!reset) begin
      q.delete(); pend = 0; m_id = 0; m_cid = 0; m_clr = 0; m_err = 0;
      return;
    end
    sz    = q.size();
    top   = (sz > 0) ? q[sz-1] : 0;
    pre   = tree_valid && (sz == 0 || int'(tree_prio) > top);
    m_err = irq_ret && (sz == 0);
    m_clr = 0;
    if (irq_ret && sz > 0) void'(q.pop_back());
    if (pend) begin
      if (irq_ack) begin
        n_tests++;
        if (q.size() >= int'(NestDepth)) begin
          n_fail++;
          $display("FAIL push_full: depth %0d required below %0d", q.size(), NestDepth);
        end
        q.push_back(rprio);
        m_clr = 1; m_cid = rid; pend = 0;
      end
    end else if (pre) begin
      pend = 1; rid = int'(tree_id); rprio = int'(tree_prio); m_id = rid;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic rst, input logic tv, input int unsigned id,
                       input int unsigned pr, input logic ack, input logic ret);
    reset = rst; tree_valid = tv; tree_id = IntIdWidth'(id);
    tree_prio = PrioWidth'(pr); irq_ack = ack; irq_ret = ret;
  endtask

  initial begin
    vec_t v;
    logic [OutW-1:0] exp;
    drive(0, 0, 0, 0, 0, 0);
    pend = 0; m_id = 0; m_cid = 0; m_clr = 0; m_err = 0; rid = 0; rprio = 0;

    // rst tv id pr ack ret | req id clr cid cur act err
    vecs.push_back(mk(0,1,4,2,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,4,2,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,4,2,0,0, 1,4,0,0,0,0,0));
    vecs.push_back(mk(1,1,4,2,1,0, 0,4,1,4,2,1,0));
    vecs.push_back(mk(1,1,4,2,0,0, 0,4,0,4,2,1,0));
    vecs.push_back(mk(1,1,4,2,0,0, 0,4,0,4,2,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,4,0,4,0,0,0));
    vecs.push_back(mk(1,1,4,2,0,0, 1,4,0,4,0,0,0));
    vecs.push_back(mk(1,1,7,3,0,0, 1,4,0,4,0,0,0));
    vecs.push_back(mk(1,1,7,3,0,0, 1,4,0,4,0,0,0));
    vecs.push_back(mk(1,1,7,3,1,0, 0,4,1,4,2,1,0));
    vecs.push_back(mk(1,1,7,3,0,0, 1,7,0,4,2,1,0));
    vecs.push_back(mk(1,1,7,3,1,0, 0,7,1,7,3,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,7,0,7,2,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,7,0,7,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,7,0,7,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0, 0,7,0,7,0,0,0));
    vecs.push_back(mk(1,1,3,1,0,0, 1,3,0,7,0,0,0));
    vecs.push_back(mk(1,1,3,1,1,0, 0,3,1,3,1,1,0));
    vecs.push_back(mk(1,1,2,2,0,0, 1,2,0,3,1,1,0));
    vecs.push_back(mk(1,1,2,2,1,0, 0,2,1,2,2,1,0));
    vecs.push_back(mk(1,1,6,2,0,0, 0,2,0,2,2,1,0));
    vecs.push_back(mk(1,1,6,2,0,0, 0,2,0,2,2,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,2,0,2,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,2,0,2,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,0,2,0,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 0,0,1,0,0,1,0));
    vecs.push_back(mk(1,1,1,1,0,0, 1,1,0,0,0,1,0));
    vecs.push_back(mk(1,1,1,1,1,0, 0,1,1,1,1,1,0));
    vecs.push_back(mk(1,1,2,2,0,0, 1,2,0,1,1,1,0));
    vecs.push_back(mk(1,1,2,2,1,0, 0,2,1,2,2,1,0));
    vecs.push_back(mk(1,1,3,3,0,0, 1,3,0,2,2,1,0));
    vecs.push_back(mk(1,1,3,3,1,0, 0,3,1,3,3,1,0));
    vecs.push_back(mk(1,1,5,3,0,0, 0,3,0,3,3,1,0));
    vecs.push_back(mk(1,1,5,3,0,0, 0,3,0,3,3,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,3,0,3,2,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,3,0,3,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,3,0,3,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,3,0,3,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,3,0,3,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0, 0,3,0,3,0,0,0));
    vecs.push_back(mk(1,1,1,1,0,0, 1,1,0,3,0,0,0));
    vecs.push_back(mk(1,1,1,1,1,0, 0,1,1,1,1,1,0));
    vecs.push_back(mk(1,1,5,3,0,0, 1,5,0,1,1,1,0));
    vecs.push_back(mk(1,1,5,3,1,1, 0,5,1,5,3,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,5,0,5,3,1,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,5,0,5,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,5,0,5,0,0,1));
    vecs.push_back(mk(1,0,0,0,1,0, 0,5,0,5,0,0,0));
    vecs.push_back(mk(1,1,2,1,0,0, 1,2,0,5,0,0,0));
    vecs.push_back(mk(1,1,2,1,1,0, 0,2,1,2,1,1,0));
    vecs.push_back(mk(1,1,6,3,0,0, 1,6,0,2,1,1,0));
    vecs.push_back(mk(1,1,6,3,0,1, 1,6,0,2,0,0,0));
    vecs.push_back(mk(1,1,6,3,1,0, 0,6,1,6,3,1,0));

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.rst, v.tv, v.id, v.pr, v.ack, v.ret);
      tick();
      exp = {v.e_req, IntIdWidth'(v.e_id), v.e_clr, IntIdWidth'(v.e_cid),
             PrioWidth'(v.e_cur), v.e_act, v.e_err};
      check($sformatf("vec%0d", i), dut_out(), exp);
    end

    // Asynchronous reset in the middle of a held request.
    drive(1, 0, 0, 0, 0, 1);
    tick();
    check("pre_async_ret", dut_out(), model_out());
    drive(1, 1, 4, 2, 0, 0);
    tick();
    check("pre_async_req", dut_out(), model_out());
    #3 reset = 1'b0;
    #1 check("async_rst", dut_out(), '0);
    tick();
    check("async_rst_hold", dut_out(), model_out());

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, IntAmount - 1), $urandom_range(0, Priorities - 1),
            logic'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      tick();
      check($sformatf("rand%0d", i), dut_out(), model_out());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
